exec_result_pipe: RTL



---
 rtl/exec_result_pipe_pkg.sv | 44 ++++
 rtl/exec_result_pipe_if.sv | 45 ++++
 rtl/exec_result_pipe_stage_reg.sv | 27 ++
 rtl/exec_result_pipe.sv | 99 +++++++++
 4 files changed

// File: rtl/exec_result_pipe_pkg.sv
// spu_pipe_pkg: packet layout shared by the result pipes, the forwarding logic and the operand muxes.
// Big-endian bit numbering: bit 0 is the packet MSB.
package spu_pipe_pkg;

    localparam int DEPTH = 7;
    localparam int PKT_W = 143;

    localparam int RESULT_LO = 0;
    localparam int RESULT_HI = 127;
    localparam int UNIT_LO   = 128;
    localparam int UNIT_HI   = 130;
    localparam int DST_LO    = 131;
    localparam int DST_HI    = 137;
    localparam int LAT_LO    = 138;
    localparam int LAT_HI    = 141;
    localparam int WR_BIT    = 142;

    localparam int RESULT_W = RESULT_HI - RESULT_LO + 1;
    localparam int UNIT_W   = UNIT_HI - UNIT_LO + 1;
    localparam int DST_W    = DST_HI - DST_LO + 1;
    localparam int LAT_W    = LAT_HI - LAT_LO + 1;

    // First member lands on bit 0, matching the published layout.
    typedef struct packed {
        logic [0:RESULT_W-1] result;
        logic [0:UNIT_W-1]   unit;
        logic [0:DST_W-1]    reg_dst;
        logic [0:LAT_W-1]    latency;
        logic                reg_wr;
    } pkt_t;

    function automatic logic lat_illegal(input logic [0:LAT_W-1] lat);
        return (lat == '0) || (lat > LAT_W'(DEPTH));
    endfunction

    // Empty or squashed stages must never match in forwarding.
    function automatic pkt_t publish(input pkt_t p, input logic valid);
        pkt_t o;
        o        = p;
        o.reg_wr = p.reg_wr & valid;
        return o;
    endfunction

endpackage

// File: rtl/exec_result_pipe_if.sv
// exec_result_pipe_if: issue, flush, stage-packet and write-back bundle of one result pipe.
// master = issue side and consumers, slave = the pipe itself.
interface exec_result_pipe_if;
    import spu_pipe_pkg::*;

    logic                iss_valid;
    logic [0:RESULT_W-1] iss_result;
    logic [0:UNIT_W-1]   iss_unit;
    logic [0:DST_W-1]    iss_reg_dst;
    logic [0:LAT_W-1]    iss_latency;
    logic                iss_reg_wr;

    logic                flush_valid;
    logic [0:2]          flush_age;

    logic [0:PKT_W-1]    packed_stage_1;
    logic [0:PKT_W-1]    packed_stage_2;
    logic [0:PKT_W-1]    packed_stage_3;
    logic [0:PKT_W-1]    packed_stage_4;
    logic [0:PKT_W-1]    packed_stage_5;
    logic [0:PKT_W-1]    packed_stage_6;
    logic [0:PKT_W-1]    packed_stage_7;

    logic                wb_en;
    logic [0:DST_W-1]    wb_reg;
    logic [0:RESULT_W-1] wb_data;
    logic                lat_err;

    modport master (
        output iss_valid, iss_result, iss_unit, iss_reg_dst, iss_latency, iss_reg_wr,
        output flush_valid, flush_age,
        input  packed_stage_1, packed_stage_2, packed_stage_3, packed_stage_4,
        input  packed_stage_5, packed_stage_6, packed_stage_7,
        input  wb_en, wb_reg, wb_data, lat_err
    );

    modport slave (
        input  iss_valid, iss_result, iss_unit, iss_reg_dst, iss_latency, iss_reg_wr,
        input  flush_valid, flush_age,
        output packed_stage_1, packed_stage_2, packed_stage_3, packed_stage_4,
        output packed_stage_5, packed_stage_6, packed_stage_7,
        output wb_en, wb_reg, wb_data, lat_err
    );

endinterface

// File: rtl/exec_result_pipe_stage_reg.sv
// pipe_stage_reg: one packet stage with valid bit, async reset and synchronous kill.
module pipe_stage_reg
    import spu_pipe_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic kill,
    input  logic d_valid,
    input  pkt_t d_pkt,
    output logic q_valid,
    output pkt_t q_pkt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_pkt   <= '0;
        end else if (kill) begin
            q_valid <= 1'b0;
            q_pkt   <= '0;
        end else begin
            q_valid <= d_valid;
            q_pkt   <= d_pkt;
        end
    end

endmodule

// File: rtl/exec_result_pipe.sv
// exec_result_pipe: seven-stage result shift pipe with register-file write-back from the last stage.
// Define EXEC_RESULT_PIPE_FLUSH_EN to build the branch-flush squash logic; otherwise flush inputs are ignored.
module exec_result_pipe
    import spu_pipe_pkg::*;
#(
    parameter int DEPTH = spu_pipe_pkg::DEPTH,
    parameter int PKT_W = spu_pipe_pkg::PKT_W
) (
    input logic               clk,
    input logic               rst_n,
    exec_result_pipe_if.slave bus
);

    pkt_t             issue_pkt;
    logic             issue_valid;
    pkt_t             q_pkt   [DEPTH];
    logic             q_valid [DEPTH];
    logic [0:PKT_W-1] pub_pkt [DEPTH];
    logic [DEPTH-1:0] kill_vec;
    logic             lat_err_q;

    always_comb begin
        issue_pkt   = '0;
        issue_valid = bus.iss_valid;
        if (bus.iss_valid) begin
            issue_pkt.result  = bus.iss_result;
            issue_pkt.unit    = bus.iss_unit;
            issue_pkt.reg_dst = bus.iss_reg_dst;
            issue_pkt.latency = bus.iss_latency;
            issue_pkt.reg_wr  = bus.iss_reg_wr;
        end
    end

`ifdef EXEC_RESULT_PIPE_FLUSH_EN
    logic [2:0] flush_span;

    // Kill index k means stage k+1; stages 1..A are cleared, which also drops the incoming issue.
    always_comb begin
        flush_span = (bus.flush_age == '0) ? 3'd1 : bus.flush_age;
        kill_vec   = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            kill_vec[k] = bus.flush_valid && (k < {29'd0, flush_span});
        end
    end
`else
    logic unused_flush;

    assign kill_vec     = '0;
    assign unused_flush = ^{bus.flush_valid, bus.flush_age};
`endif

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            pipe_stage_reg u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .kill    (kill_vec[i]),
                .d_valid (issue_valid),
                .d_pkt   (issue_pkt),
                .q_valid (q_valid[i]),
                .q_pkt   (q_pkt[i])
            );
        end else begin : g_body
            pipe_stage_reg u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .kill    (kill_vec[i]),
                .d_valid (q_valid[i-1]),
                .d_pkt   (q_pkt[i-1]),
                .q_valid (q_valid[i]),
                .q_pkt   (q_pkt[i])
            );
        end
        assign pub_pkt[i] = publish(q_pkt[i], q_valid[i]);
    end

    assign bus.packed_stage_1 = pub_pkt[0];
    assign bus.packed_stage_2 = pub_pkt[1];
    assign bus.packed_stage_3 = pub_pkt[2];
    assign bus.packed_stage_4 = pub_pkt[3];
    assign bus.packed_stage_5 = pub_pkt[4];
    assign bus.packed_stage_6 = pub_pkt[5];
    assign bus.packed_stage_7 = pub_pkt[6];

    assign bus.wb_en   = q_valid[DEPTH-1] & q_pkt[DEPTH-1].reg_wr;
    assign bus.wb_reg  = q_pkt[DEPTH-1].reg_dst;
    assign bus.wb_data = q_pkt[DEPTH-1].result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_err_q <= 1'b0;
        end else if (bus.iss_valid && lat_illegal(bus.iss_latency)) begin
            lat_err_q <= 1'b1;
        end
    end

    assign bus.lat_err = lat_err_q;

endmodule
